// File: rtl/count_capture_if.sv
// Settled-count output channel: valid/ready handshake carrying one counter value.
interface count_capture_if #(parameter int WIDTH = 4);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_count;

    modport master (output out_valid, output out_count, input out_ready);
    modport slave  (input out_valid, input out_count, output out_ready);
endinterface

// File: rtl/count_capture.sv
// Captures settled values from an asynchronous ripple counter and publishes them on a valid/ready channel.
// Optional wrap-event counter enabled by defining COUNT_CAPTURE_WRAP_EN.
module count_capture #(
    parameter int WIDTH  = 4,
    parameter int STABLE = 2
`ifdef COUNT_CAPTURE_WRAP_EN
    , parameter int WRAP_W = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] q_in,
    count_capture_if.master  bus,
    output logic             tc_pulse,
    output logic             overrun
`ifdef COUNT_CAPTURE_WRAP_EN
    , output logic [WRAP_W-1:0] wrap_count
`endif
);
    localparam int SW = $clog2(STABLE + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [WIDTH-1:0] s1, s2, s2_d, last_acc;
    logic [SW-1:0]    stab_cnt;
    logic             accept, load, drop;
    state_t           state, nstate;

    // s2 has matched s2_d for exactly STABLE-1 prior edges and again now: first settled edge only
    assign accept = enable && (s2 == s2_d) && (stab_cnt == SW'(STABLE - 1)) && (s2 != last_acc);
    assign drop   = (state == HOLD) && accept && !bus.out_ready;
    assign bus.out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1       <= '0;
            s2       <= '0;
            s2_d     <= '0;
            stab_cnt <= '0;
            last_acc <= '0;
        end else begin
            s1   <= q_in;
            s2   <= s1;
            s2_d <= s2;
            if (!enable || (s2 != s2_d))
                stab_cnt <= '0;
            else if (stab_cnt != SW'(STABLE))
                stab_cnt <= stab_cnt + 1'b1;
            if (accept)
                last_acc <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            bus.out_count <= '0;
            tc_pulse      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state    <= nstate;
            tc_pulse <= accept && (s2 == {WIDTH{1'b1}});
            if (load)
                bus.out_count <= s2;
            if (drop)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        nstate = state;
        load   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load   = 1'b1;
                    nstate = HOLD;
                end
            end
            HOLD: begin
                // a consumed value can be replaced in the same edge without leaving HOLD
                if (bus.out_ready && accept)
                    load = 1'b1;
                else if (bus.out_ready)
                    nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

`ifdef COUNT_CAPTURE_WRAP_EN
    always_ff @(posedge clk) begin
        if (!reset)
            wrap_count <= '0;
        else if (accept && (s2 < last_acc) && (wrap_count != {WRAP_W{1'b1}}))
            wrap_count <= wrap_count + 1'b1;
    end
`endif
endmodule
